// File: rtl/rvfpm_issue_tracker.sv
// Issue queue plus pipeline occupancy shadow for the rvfpm FPU.
// Instructions are enqueued with their XIF id, advance through the stages, and can be killed by id.
module rvfpm_issue_tracker #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned PIPELINE_STAGES = 4,
  parameter int unsigned INSTR_WIDTH     = 32
) (
  input  logic                                   ck,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [INSTR_WIDTH-1:0]                 in_instr,
  input  logic [X_ID_WIDTH-1:0]                  in_id,
  input  logic                                   pipe_stall,
  input  logic                                   kill_valid,
  input  logic [X_ID_WIDTH-1:0]                  kill_id,
  output logic                                   out_valid,
  output logic [INSTR_WIDTH-1:0]                 out_instr,
  output logic [X_ID_WIDTH-1:0]                  out_id,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]       queue_count,
  output logic [QUEUE_DEPTH*X_ID_WIDTH-1:0]      queue_ids,
  output logic [PIPELINE_STAGES-1:0]             pipe_valid,
  output logic [PIPELINE_STAGES*X_ID_WIDTH-1:0]  pipe_ids
);

  localparam int unsigned PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned LAST = PIPELINE_STAGES - 1;

  logic [INSTR_WIDTH-1:0]  r_q_instr [QUEUE_DEPTH];
  logic [X_ID_WIDTH-1:0]   r_q_id    [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  r_q_live;
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [CW-1:0]           r_count;

  logic [INSTR_WIDTH-1:0]     r_s_instr [PIPELINE_STAGES];
  logic [X_ID_WIDTH-1:0]      r_s_id    [PIPELINE_STAGES];
  logic [PIPELINE_STAGES-1:0] r_s_valid;

  logic                       w_acc;
  logic                       w_deq;
  logic                       w_head_live;
  logic [PIPELINE_STAGES-1:0] w_s_hit;

  assign in_ready    = !rst && (r_count < CW'(QUEUE_DEPTH));
  assign w_acc       = in_valid && in_ready;
  assign w_deq       = !pipe_stall && (r_count != '0);
  // Head survives into stage 0 only if it is live and not hit by this edge's kill.
  assign w_head_live = w_deq && r_q_live[r_head] &&
                       !(kill_valid && (r_q_id[r_head] == kill_id));

  always_comb begin
    w_s_hit = '0;
    for (int k = 0; k < int'(PIPELINE_STAGES); k++) begin
      w_s_hit[k] = kill_valid && (r_s_id[k] == kill_id);
    end
  end

  // Issue queue: kill marks entries dead in place; a same-edge accept overrides its own slot.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        r_q_instr[i] <= '0;
        r_q_id[i]    <= '0;
      end
      r_q_live <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      if (kill_valid) begin
        for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
          if (r_q_id[i] == kill_id) r_q_live[i] <= 1'b0;
        end
      end
      if (w_acc) begin
        r_q_instr[r_tail] <= in_instr;
        r_q_id[r_tail]    <= in_id;
        r_q_live[r_tail]  <= 1'b1;
        r_tail            <= (r_tail == PW'(QUEUE_DEPTH - 1)) ? '0 : r_tail + PW'(1);
      end
      if (w_deq) begin
        r_head <= (r_head == PW'(QUEUE_DEPTH - 1)) ? '0 : r_head + PW'(1);
      end
      case ({w_acc, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pipeline shadow: kill is applied at the destination stage after the shift.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(PIPELINE_STAGES); k++) begin
        r_s_instr[k] <= '0;
        r_s_id[k]    <= '0;
      end
      r_s_valid <= '0;
    end else if (pipe_stall) begin
      for (int k = 0; k < int'(PIPELINE_STAGES); k++) begin
        if (w_s_hit[k]) r_s_valid[k] <= 1'b0;
      end
    end else begin
      for (int k = 1; k < int'(PIPELINE_STAGES); k++) begin
        r_s_valid[k] <= r_s_valid[k-1] && !w_s_hit[k-1];
        r_s_id[k]    <= r_s_id[k-1];
        r_s_instr[k] <= r_s_instr[k-1];
      end
      r_s_valid[0] <= w_head_live;
      r_s_id[0]    <= w_head_live ? r_q_id[r_head] : '0;
      r_s_instr[0] <= w_head_live ? r_q_instr[r_head] : '0;
    end
  end

  assign queue_count = r_count;

  // Queue view in FIFO order, head first, unoccupied slots zero.
  always_comb begin
    int unsigned idx;
    queue_ids = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      idx = 32'(r_head) + i;
      if (idx >= QUEUE_DEPTH) idx = idx - QUEUE_DEPTH;
      if (i < 32'(r_count)) begin
        queue_ids[i*X_ID_WIDTH +: X_ID_WIDTH] = r_q_id[PW'(idx)];
      end
    end
  end

  always_comb begin
    pipe_valid = r_s_valid;
    pipe_ids   = '0;
    for (int k = 0; k < int'(PIPELINE_STAGES); k++) begin
      if (r_s_valid[k]) pipe_ids[k*X_ID_WIDTH +: X_ID_WIDTH] = r_s_id[k];
    end
    out_valid = r_s_valid[LAST];
    out_id    = r_s_valid[LAST] ? r_s_id[LAST] : '0;
    out_instr = r_s_valid[LAST] ? r_s_instr[LAST] : '0;
  end

endmodule
